// File: rtl/box_pkg.sv
// box_pkg: box state type, screen/template defaults and clamp helpers for multi_box_tracker.
// Coordinates are held at BOX_W bits so edge sums never wrap for any COORD_W up to BOX_W-1.
package box_pkg;

  localparam int unsigned BOX_W          = 16;
  localparam int unsigned DEF_SCREEN_W   = 640;
  localparam int unsigned DEF_SCREEN_H   = 480;
  localparam int unsigned DEF_TEMPLATE_W = 32;

  typedef logic [BOX_W-1:0] coord_t;

  typedef struct packed {
    coord_t cx;
    coord_t cy;
    coord_t hw;
    coord_t hh;
  } box_t;

  function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic coord_t max_c(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_box_tracker_if.sv
// Pixel-pipeline and tracker-peak bundle for multi_box_tracker; slave is the tracker side.
interface multi_box_tracker_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned IDX_W   = 2
);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               max_ready;
  logic [COORD_W-1:0] max_x;
  logic [COORD_W-1:0] max_y;
  logic               draw_box;
  logic               draw_active;
  logic               in_box;
  logic [IDX_W-1:0]   hit_idx;
  logic               template_in_box;
  logic               template_start;

  modport master (
    output x, y, max_ready, max_x, max_y,
    input  draw_box, draw_active, in_box, hit_idx, template_in_box, template_start
  );

  modport slave (
    input  x, y, max_ready, max_x, max_y,
    output draw_box, draw_active, in_box, hit_idx, template_in_box, template_start
  );

endinterface

// File: rtl/multi_box_tracker_button_repeater.sv
// button_repeater: turns a level button into single-cycle step pulses (press, then hold/repeat).
// EDGE_ONLY = 1 gives exactly one step per press; the hold counter then stays idle.
module button_repeater #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_500_000,
  parameter bit          EDGE_ONLY     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WRAP_V = CNT_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             held;
  logic [CNT_W-1:0] cnt;

  // cnt is the number of held cycles since the press, folded back to HOLD_V every repeat period
  always_ff @(posedge clk) begin
    if (!rst_n || !btn) begin
      held <= 1'b0;
      cnt  <= '0;
    end else if (!held) begin
      held <= 1'b1;
      cnt  <= ONE;
    end else if (!EDGE_ONLY) begin
      cnt <= (cnt == WRAP_V) ? HOLD_V : cnt + ONE;
    end
  end

  assign step = btn && (!held || (!EDGE_ONLY && cnt == HOLD_V));

endmodule

// File: rtl/multi_box_tracker.sv
// multi_box_tracker: NUM_BOXES on-screen-clamped overlay boxes; the active one follows buttons or the tracker peak.
// Define MULTI_BOX_AUTOREPEAT_EN for press/hold/repeat buttons; otherwise one step per button rising edge.
module multi_box_tracker
  import box_pkg::*;
#(
  parameter int unsigned NUM_BOXES     = 4,
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned SCREEN_W      = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H      = DEF_SCREEN_H,
  parameter int unsigned MIN_HALF      = 5,
  parameter int unsigned MAX_HALF      = 64,
  parameter int unsigned DEFAULT_HALF  = 16,
  parameter int unsigned TEMPLATE_W    = DEF_TEMPLATE_W,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_500_000,
  localparam int unsigned IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               move_up,
  input  logic               move_down,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               mode,
  input  logic               select_next,
  input  logic               tracking_mode,
  multi_box_tracker_if.slave pix,
  output logic [COORD_W-1:0] template_top,
  output logic [COORD_W-1:0] template_left,
  output logic [IDX_W-1:0]   active_idx,
  output logic [COORD_W-1:0] left,
  output logic [COORD_W-1:0] right,
  output logic [COORD_W-1:0] top,
  output logic [COORD_W-1:0] bottom
);

`ifdef MULTI_BOX_AUTOREPEAT_EN
  localparam bit EDGE_ONLY = 1'b0;
`else
  localparam bit EDGE_ONLY = 1'b1;
`endif

  localparam coord_t ONE    = coord_t'(1);
  localparam coord_t HALF_T = coord_t'(TEMPLATE_W / 2);
  localparam coord_t MAX_X  = coord_t'(SCREEN_W - 1);
  localparam coord_t MAX_Y  = coord_t'(SCREEN_H - 1);
  localparam coord_t MIN_H  = coord_t'(MIN_HALF);
  localparam coord_t MAX_H  = coord_t'(MAX_HALF);
  localparam coord_t DEF_H  = coord_t'(DEFAULT_HALF);
  localparam coord_t CTR_X  = coord_t'(SCREEN_W / 2);
  localparam coord_t CTR_Y  = coord_t'(SCREEN_H / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic step_up, step_down, step_left, step_right, step_sel;

  button_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .EDGE_ONLY(EDGE_ONLY))
    u_rep_up    (.clk(clk), .rst_n(rst_n), .btn(move_up),    .step(step_up));
  button_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .EDGE_ONLY(EDGE_ONLY))
    u_rep_down  (.clk(clk), .rst_n(rst_n), .btn(move_down),  .step(step_down));
  button_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .EDGE_ONLY(EDGE_ONLY))
    u_rep_left  (.clk(clk), .rst_n(rst_n), .btn(move_left),  .step(step_left));
  button_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .EDGE_ONLY(EDGE_ONLY))
    u_rep_right (.clk(clk), .rst_n(rst_n), .btn(move_right), .step(step_right));
  button_repeater #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .EDGE_ONLY(1'b1))
    u_rep_sel   (.clk(clk), .rst_n(rst_n), .btn(select_next), .step(step_sel));

  box_t   boxes [NUM_BOXES];
  box_t   act, nxt;
  coord_t mx, my, cand_w, cand_h;
  logic   inc_x, dec_x, inc_y, dec_y;

  // Centre load/move first, then the resize is checked against the already-updated centre.
  always_comb begin
    act    = boxes[active_idx];
    nxt    = act;
    mx     = max_c(act.hw, HALF_T);
    my     = max_c(act.hh, HALF_T);
    cand_w = '0;
    cand_h = '0;
    inc_x  = step_right && !step_left && !step_sel;
    dec_x  = step_left && !step_right && !step_sel;
    inc_y  = step_down && !step_up && !step_sel;
    dec_y  = step_up && !step_down && !step_sel;
    if (tracking_mode && pix.max_ready) begin
      nxt.cx = clamp(coord_t'(pix.max_x), mx, MAX_X - mx);
      nxt.cy = clamp(coord_t'(pix.max_y), my, MAX_Y - my);
    end else if (mode && !tracking_mode) begin
      if (inc_x) nxt.cx = clamp(act.cx + ONE, mx, MAX_X - mx);
      if (dec_x) nxt.cx = clamp(act.cx - ONE, mx, MAX_X - mx);
      if (inc_y) nxt.cy = clamp(act.cy + ONE, my, MAX_Y - my);
      if (dec_y) nxt.cy = clamp(act.cy - ONE, my, MAX_Y - my);
    end
    if (!mode) begin
      if (inc_x) begin
        cand_w = act.hw + ONE;
        if (cand_w <= MAX_H && nxt.cx >= cand_w && nxt.cx + cand_w <= MAX_X) nxt.hw = cand_w;
      end else if (dec_x) begin
        cand_w = act.hw - ONE;
        if (cand_w >= MIN_H) nxt.hw = cand_w;
      end
      if (inc_y) begin
        cand_h = act.hh + ONE;
        if (cand_h <= MAX_H && nxt.cy >= cand_h && nxt.cy + cand_h <= MAX_Y) nxt.hh = cand_h;
      end else if (dec_y) begin
        cand_h = act.hh - ONE;
        if (cand_h >= MIN_H) nxt.hh = cand_h;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BOXES; i++)
        boxes[i] <= '{cx: CTR_X, cy: CTR_Y, hw: DEF_H, hh: DEF_H};
      active_idx <= '0;
    end else begin
      boxes[active_idx] <= nxt;
      if (step_sel) active_idx <= (active_idx == LAST_IDX) ? '0 : active_idx + IDX_ONE;
    end
  end

  coord_t tpl_l, tpl_t;

  assign tpl_l         = act.cx - HALF_T;
  assign tpl_t         = act.cy - HALF_T;
  assign left          = COORD_W'(act.cx - act.hw);
  assign right         = COORD_W'(act.cx + act.hw);
  assign top           = COORD_W'(act.cy - act.hh);
  assign bottom        = COORD_W'(act.cy + act.hh);
  assign template_left = COORD_W'(tpl_l);
  assign template_top  = COORD_W'(tpl_t);

  coord_t bl [NUM_BOXES];
  coord_t br [NUM_BOXES];
  coord_t bt [NUM_BOXES];
  coord_t bb [NUM_BOXES];

  always_comb begin
    for (int unsigned i = 0; i < NUM_BOXES; i++) begin
      bl[i] = boxes[i].cx - boxes[i].hw;
      br[i] = boxes[i].cx + boxes[i].hw;
      bt[i] = boxes[i].cy - boxes[i].hh;
      bb[i] = boxes[i].cy + boxes[i].hh;
    end
  end

  coord_t               px, py;
  logic [NUM_BOXES-1:0] span, outline;
  logic [IDX_W-1:0]     hit_c;
  logic                 found, tpl_in_c, tpl_start_c;

  always_comb begin
    px      = coord_t'(pix.x);
    py      = coord_t'(pix.y);
    span    = '0;
    outline = '0;
    hit_c   = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_BOXES; i++) begin
      span[i]    = px >= bl[i] && px <= br[i] && py >= bt[i] && py <= bb[i];
      outline[i] = span[i] && (px == bl[i] || px == br[i] || py == bt[i] || py == bb[i]);
      if (outline[i] && !found) begin
        hit_c = IDX_W'(i);
        found = 1'b1;
      end
    end
    tpl_in_c    = px >= tpl_l && px < act.cx + HALF_T && py >= tpl_t && py < act.cy + HALF_T;
    tpl_start_c = px == tpl_l && py == tpl_t;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix.draw_box        <= 1'b0;
      pix.draw_active     <= 1'b0;
      pix.in_box          <= 1'b0;
      pix.hit_idx         <= '0;
      pix.template_in_box <= 1'b0;
      pix.template_start  <= 1'b0;
    end else begin
      pix.draw_box        <= |outline;
      pix.draw_active     <= outline[active_idx];
      pix.in_box          <= span[active_idx];
      pix.hit_idx         <= hit_c;
      pix.template_in_box <= tpl_in_c;
      pix.template_start  <= tpl_start_c;
    end
  end

endmodule

// File: tb/tb_multi_box_tracker.sv
// Directed bench for multi_box_tracker (4 boxes, HOLD_CYCLES = 10, REPEAT_CYCLES = 4).
// Hold-test expectation follows MULTI_BOX_AUTOREPEAT_EN.
module tb_multi_box_tracker;

`ifdef MULTI_BOX_AUTOREPEAT_EN
  localparam int HOLD_STEPS = 6;
`else
  localparam int HOLD_STEPS = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       move_up, move_down, move_left, move_right;
  logic       mode, select_next, tracking_mode;
  logic [9:0] template_top, template_left;
  logic [1:0] active_idx;
  logic [9:0] left, right, top, bottom;

  int vectors     = 0;
  int miscompares = 0;

  multi_box_tracker_if #(.COORD_W(10), .IDX_W(2)) pix ();

  multi_box_tracker #(
    .NUM_BOXES(4), .COORD_W(10), .SCREEN_W(640), .SCREEN_H(480),
    .MIN_HALF(5), .MAX_HALF(64), .DEFAULT_HALF(16), .TEMPLATE_W(32),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .mode(mode), .select_next(select_next), .tracking_mode(tracking_mode),
    .pix(pix),
    .template_top(template_top), .template_left(template_left), .active_idx(active_idx),
    .left(left), .right(right), .top(top), .bottom(bottom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int dir, input logic v);
    case (dir)
      0: move_up = v;
      1: move_down = v;
      2: move_left = v;
      3: move_right = v;
      default: select_next = v;
    endcase
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right, 4 select_next
  task automatic press(input int dir, input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(dir, 1'b1);
      tick();
      set_btn(dir, 1'b0);
      tick();
    end
  endtask

  task automatic pixel(input int px, input int py);
    pix.x = 10'(px);
    pix.y = 10'(py);
    tick();
  endtask

  task automatic load_peak(input int mxv, input int myv, input logic with_sel);
    pix.max_x     = 10'(mxv);
    pix.max_y     = 10'(myv);
    pix.max_ready = 1'b1;
    select_next   = with_sel;
    tick();
    pix.max_ready = 1'b0;
    select_next   = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    {move_up, move_down, move_left, move_right} = '0;
    mode = 1'b0; select_next = 1'b0; tracking_mode = 1'b0;
    pix.x = '0; pix.y = '0; pix.max_ready = 1'b0; pix.max_x = '0; pix.max_y = '0;
    repeat (3) tick();
    check("rst_draw_box", 32'(pix.draw_box), 0);
    check("rst_template_start", 32'(pix.template_start), 0);
    check("rst_active_idx", 32'(active_idx), 0);
    rst_n = 1'b1;
    check("rst_left", 32'(left), 304);
    check("rst_right", 32'(right), 336);
    check("rst_top", 32'(top), 224);
    check("rst_bottom", 32'(bottom), 256);
    check("rst_tpl_left", 32'(template_left), 304);
    check("rst_tpl_top", 32'(template_top), 224);

    // box 0 top-left corner, then right edge, centre and just outside
    pixel(304, 224);
    check("corner_draw_box", 32'(pix.draw_box), 1);
    check("corner_draw_active", 32'(pix.draw_active), 1);
    check("corner_hit_idx", 32'(pix.hit_idx), 0);
    check("corner_in_box", 32'(pix.in_box), 1);
    check("corner_tpl_start", 32'(pix.template_start), 1);
    check("corner_tpl_in", 32'(pix.template_in_box), 1);
    pixel(336, 240);
    check("redge_draw_box", 32'(pix.draw_box), 1);
    check("redge_in_box", 32'(pix.in_box), 1);
    check("redge_tpl_in", 32'(pix.template_in_box), 0);
    check("redge_tpl_start", 32'(pix.template_start), 0);
    pixel(320, 240);
    check("centre_draw_box", 32'(pix.draw_box), 0);
    check("centre_in_box", 32'(pix.in_box), 1);
    check("centre_tpl_in", 32'(pix.template_in_box), 1);
    pixel(337, 240);
    check("outside_in_box", 32'(pix.in_box), 0);

    // resize box 0 to both half-width limits
    mode = 1'b0;
    press(3, 48);
    check("grow_right", 32'(right), 384);
    check("grow_left", 32'(left), 256);
    press(3, 1);
    check("max_half_right", 32'(right), 384);
    press(2, 59);
    check("shrink_left", 32'(left), 315);
    press(2, 1);
    check("min_half_left", 32'(left), 315);
    move_left = 1'b1; move_right = 1'b1;
    tick();
    move_left = 1'b0; move_right = 1'b0;
    tick();
    check("opposing_left", 32'(left), 315);
    press(1, 1);
    check("grow_hh_bottom", 32'(bottom), 257);
    check("grow_hh_top", 32'(top), 223);
    press(0, 1);
    check("shrink_hh_bottom", 32'(bottom), 256);

    // box 1: widen to hw 32, then drive hard left against the clamp
    press(4, 1);
    check("sel_idx1", 32'(active_idx), 1);
    check("box1_left_default", 32'(left), 304);
    press(3, 16);
    check("box1_hw32_left", 32'(left), 288);
    mode = 1'b1;
    press(2, 700);
    check("clamp_left_edge", 32'(left), 0);
    check("clamp_right_edge", 32'(right), 64);
    pixel(0, 230);
    check("box1_draw_box", 32'(pix.draw_box), 1);
    check("box1_draw_active", 32'(pix.draw_active), 1);
    check("box1_hit_idx", 32'(pix.hit_idx), 1);
    press(4, 1);
    check("sel_idx2", 32'(active_idx), 2);
    check("box2_left", 32'(left), 304);
    pixel(0, 230);
    check("box1_inactive_draw_active", 32'(pix.draw_active), 0);
    check("box1_inactive_hit_idx", 32'(pix.hit_idx), 1);
    press(4, 1);
    check("sel_idx3", 32'(active_idx), 3);

    // select_next with a move in the same cycle: move dropped
    move_up = 1'b1; select_next = 1'b1;
    tick();
    move_up = 1'b0; select_next = 1'b0;
    tick();
    check("sel_wrap_idx0", 32'(active_idx), 0);
    check("box0_unchanged_left", 32'(left), 315);
    check("box0_unchanged_top", 32'(top), 224);
    pixel(304, 223);
    check("box3_not_moved", 32'(pix.draw_box), 0);
    press(0, 1);
    check("move_up_top", 32'(top), 223);
    press(1, 1);
    check("move_down_top", 32'(top), 224);

    // tracking on box 0 (hw 5, hh 16)
    tracking_mode = 1'b1;
    load_peak(639, 100, 1'b0);
    check("trk_left", 32'(left), 618);
    check("trk_right", 32'(right), 628);
    check("trk_top", 32'(top), 84);
    check("trk_bottom", 32'(bottom), 116);
    check("trk_tpl_left", 32'(template_left), 607);
    check("trk_tpl_top", 32'(template_top), 84);
    press(2, 1);
    check("trk_move_ignored", 32'(left), 618);
    mode = 1'b0;
    press(3, 1);
    check("trk_resize_right", 32'(right), 629);
    press(2, 1);
    check("trk_resize_back", 32'(left), 618);
    load_peak(0, 479, 1'b0);
    check("trk_clamp_left", 32'(left), 11);
    check("trk_clamp_bottom", 32'(bottom), 479);
    check("trk_clamp_tpl_left", 32'(template_left), 0);
    check("trk_clamp_tpl_top", 32'(template_top), 447);
    load_peak(400, 300, 1'b1);
    check("trk_sel_idx", 32'(active_idx), 1);
    check("trk_sel_box1_left", 32'(left), 0);
    pixel(395, 300);
    check("trk_sel_old_box_draw", 32'(pix.draw_box), 1);
    check("trk_sel_old_box_hit", 32'(pix.hit_idx), 0);
    check("trk_sel_old_box_active", 32'(pix.draw_active), 0);
    tracking_mode = 1'b0;

    // hold move_down on box 1 for 30 cycles
    mode = 1'b1;
    move_down = 1'b1;
    repeat (30) tick();
    move_down = 1'b0;
    tick();
    check("hold_bottom", 32'(bottom), 256 + HOLD_STEPS);

    // reset while held: a still-held button is a fresh press afterwards
    move_down = 1'b1;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    move_down = 1'b0;
    tick();
    check("rst_hold_idx", 32'(active_idx), 0);
    check("rst_hold_bottom", 32'(bottom), 257);
    check("rst_hold_top", 32'(top), 225);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
